// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - set-associative instruction cache with line refill and flush
module icache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        valid_from_ifetch,
    input  logic [31:0] pc_from_ifetch,
    output logic        valid_to_ifetch,
    output logic [31:0] data_to_ifetch,
    output logic        valid_to_memctrl,
    output logic [31:0] addr_to_memctrl,
    input  logic        valid_from_memctrl,
    input  logic [31:0] data_from_memctrl
);

    localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Cache arrays; only valid bits and replacement pointers need a reset value.
    logic [WAYS-1:0]  valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [31:0]      data_q  [SETS][WAYS][LINE_WORDS];
    logic [WAY_W-1:0] rr_q    [SETS];

    // Refill bookkeeping: which line is being fetched and where it goes.
    logic             mem_valid_q, mem_valid_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] line_idx_q;
    logic [WAY_W-1:0] line_way_q;
    logic [TAG_W-1:0] line_tag_q;

    // Request address decomposition.
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [CNT_W-1:0] req_word;
    logic [31:0]      req_base;

    assign req_idx  = pc_from_ifetch[OFF_W+IDX_W-1:OFF_W];
    assign req_tag  = pc_from_ifetch[31:OFF_W+IDX_W];
    assign req_word = CNT_W'((pc_from_ifetch >> 2) & (LINE_WORDS - 1));
    assign req_base = {pc_from_ifetch[31:OFF_W], {OFF_W{1'b0}}};

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic [31:0]      hit_data;
    logic             launch;
    logic             fill_we;
    logic             last_word;
    logic             fill_done;
    logic [WAY_W-1:0] rr_next;

    // Tag compare across all ways; scanning downward lets the lowest hitting way win.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_from_ifetch && valid_q[req_idx][WAY_W'(w)] &&
                tag_q[req_idx][WAY_W'(w)] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim choice: lowest free way first, otherwise the set's round-robin pointer.
    always_comb begin
        victim = rr_q[req_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][WAY_W'(w)]) begin
                victim = WAY_W'(w);
            end
        end
    end

    assign hit_data  = data_q[req_idx][hit_way][req_word];
    assign launch    = rdy && (state_q == S_IDLE) && valid_from_ifetch && !hit && !flush;
    assign fill_we   = !rst && rdy && (state_q == S_REFILL) && valid_from_memctrl && !flush;
    assign last_word = (cnt_q == CNT_W'(LINE_WORDS - 1));
    assign fill_done = fill_we && last_word;
    assign rr_next   = (WAYS == 1) ? '0 : line_way_q + WAY_W'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a miss starts a refill; the last word or a flush ends it.
    always_comb begin
        state_d = state_q;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        state_d = S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (flush || fill_done) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Fetch-side outputs: array hit in IDLE, critical-word forward in REFILL.
    always_comb begin
        valid_to_ifetch = 1'b0;
        data_to_ifetch  = '0;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        valid_to_ifetch = 1'b1;
                        data_to_ifetch  = hit_data;
                    end
                end
                S_REFILL: begin
                    if (valid_from_memctrl && valid_from_ifetch &&
                        pc_from_ifetch[31:2] == addr_q[31:2]) begin
                        valid_to_ifetch = 1'b1;
                        data_to_ifetch  = data_from_memctrl;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory request next-state: word address walks the line, request drops at the end.
    always_comb begin
        mem_valid_d = mem_valid_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        if (launch) begin
            mem_valid_d = 1'b1;
            addr_d      = req_base;
            cnt_d       = '0;
        end else if (rdy && state_q == S_REFILL) begin
            if (flush) begin
                mem_valid_d = 1'b0;
            end else if (fill_we) begin
                if (last_word) begin
                    mem_valid_d = 1'b0;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    addr_d = addr_q + 32'd4;
                end
            end
        end
    end

    // Memory request registers and the latched destination of the line in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            line_idx_q  <= '0;
            line_way_q  <= '0;
            line_tag_q  <= '0;
        end else if (rdy) begin
            mem_valid_q <= mem_valid_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            if (launch) begin
                line_idx_q <= req_idx;
                line_way_q <= victim;
                line_tag_q <= req_tag;
            end
        end
    end

    // Valid bits and replacement pointers: cleared by reset or flush, set on line completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '{default: '0};
            rr_q    <= '{default: '0};
        end else if (rdy && flush) begin
            valid_q <= '{default: '0};
            rr_q    <= '{default: '0};
        end else if (fill_done) begin
            valid_q[line_idx_q][line_way_q] <= 1'b1;
            rr_q[line_idx_q]                <= rr_next;
        end
    end

    // Tag and data storage, written word by word as memctrl answers.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[line_idx_q][line_way_q][cnt_q] <= data_from_memctrl;
        end
        if (fill_done) begin
            tag_q[line_idx_q][line_way_q] <= line_tag_q;
        end
    end

    assign valid_to_memctrl = mem_valid_q;
    assign addr_to_memctrl  = addr_q;

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
Parametrised set-associative instruction cache between ifetch and memctrl. It generalises the direct-mapped single-word cache to N ways, multi-word lines, per-set round-robin replacement, critical-word forwarding during refill, and a whole-cache flush. Hits return combinationally in the request cycle. Misses refill a full line word-by-word through the existing single-word memctrl handshake.

Parameters:
WAYS, 2, associativity; power of two, ≥1.
SETS, 64, number of sets; power of two, ≥2.
LINE_WORDS, 4, 32-bit words per line; power of two, ≥1.
Derived: OFF_W = log2(LINE_WORDS)+2, IDX_W = log2(SETS); offset = pc[OFF_W-1:0], index = pc[OFF_W+IDX_W-1:OFF_W], tag = pc[31:OFF_W+IDX_W].

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global ready; low = freeze
flush  in  1  invalidate entire cache (one-cycle pulse)
valid_from_ifetch  in  1  fetch request valid
pc_from_ifetch  in  32  fetch address; bits [1:0] ignored
valid_to_ifetch  out  1  data_to_ifetch valid this cycle (combinational)
data_to_ifetch  out  32  instruction word
valid_to_memctrl  out  1  word read request, held until answered
addr_to_memctrl  out  32  word-aligned read address
valid_from_memctrl  in  1  one-cycle pulse: data for addr_to_memctrl
data_from_memctrl  in  32  returned word

Behaviour:
- Reset (rst=1 at posedge, overrides rdy and all else): all valid bits 0, all replacement pointers 0, state IDLE, valid_to_memctrl 0, addr_to_memctrl 0, refill counter 0. Tag/data arrays need not be cleared. Reset mid-refill abandons the line; no line becomes valid.
- rdy=0: no state, array, pointer or output-register update. valid_to_ifetch forced 0.
- States: IDLE, REFILL.
- Hit is combinational: valid_from_ifetch && any way w with valid[set][w] && tag[set][w]==tag(pc). Only evaluated in IDLE.
  - On hit: valid_to_ifetch=1 and data_to_ifetch = data[set][hit_way][word(pc)] in the same cycle.
  - Multiple hitting ways is illegal; the lowest index wins.
- IDLE miss (valid_from_ifetch=1, no hit, flush=0):
  - Latch line base = {pc[31:OFF_W], OFF_W'b0}, set and victim way.
  - Victim is the lowest-index invalid way in the set; if none, the set's round-robin pointer.
  - Next cycle: valid_to_memctrl=1, addr_to_memctrl=line base, counter=0, state REFILL.
  - valid_from_ifetch=0 in IDLE issues no request.
- REFILL, per valid_from_memctrl pulse:
  - Write data_from_memctrl into data[set][victim][counter].
  - If counter < LINE_WORDS-1: increment counter; addr_to_memctrl += 4 next cycle; valid_to_memctrl stays 1.
  - On the last word: tag[set][victim] <= latched tag; valid[set][victim] <= 1; pointer[set] <= victim+1 (mod WAYS); valid_to_memctrl <= 0; state IDLE.
  - The refilled line hits from the following cycle. No bubble is required beyond that.
- Critical-word forwarding in REFILL: valid_to_ifetch=1 and data_to_ifetch=data_from_memctrl when valid_from_memctrl && valid_from_ifetch && pc_from_ifetch[31:2]==addr_to_memctrl[31:2]. Otherwise valid_to_ifetch=0 in REFILL.
- A pc change during REFILL does not abort it; the line completes and the new pc is serviced in IDLE afterwards.
- Flush:
  - Clears all valid bits at the posedge and resets pointers to 0.
  - In REFILL: abort, valid_to_memctrl <= 0, state IDLE, victim line not validated. A valid_from_memctrl in the same cycle is discarded.
  - Flush in IDLE suppresses a miss launch that cycle; hit output still follows the arrays that cycle.
  - Memctrl treats deassertion of valid_to_memctrl as a cancel.
- valid_to_memctrl never toggles within a line except on last word, flush or reset.
- LINE_WORDS=1 degenerates to a single-word refill.

Test Plan:
- Cold miss, default params: pc=0x100 → requests 0x100,0x104,0x108,0x10C in order. Word 0x100 forwarded on its return pulse. After completion, pc=0x10C hits combinationally with valid_to_memctrl=0.
- Conflict/replacement: fill 0x100 (way0), 0x500 (way1; both index 16), then miss 0x900 → evicts way0. Afterwards 0x500 hits, 0x100 misses, and refilling 0x100 evicts way1 (0x500).
- Flush mid-refill: miss 0x200, flush after 2nd word → valid_to_memctrl 0 next cycle, state IDLE. pc=0x200 misses again; earlier-filled 0x100 also misses.
- rdy=0 for 5 cycles during REFILL with memctrl idle → addr_to_memctrl, counter and valid_to_memctrl unchanged; valid_to_ifetch=0. Refill resumes and completes correctly after rdy=1.
- Reset asserted mid-refill → next cycle valid_to_memctrl=0, addr_to_memctrl=0. Any prior line misses, and data_from_memctrl pulses are ignored.
- pc changes 0x104→0x300 mid-refill of 0x100 → line 0x100 completes. No forwarding for 0x300. 0x300 miss is launched the cycle after returning to IDLE.
